shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning the data width in bits; only the value 16 is required to be supported.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The module SHALL have port op, input, 2 bits: operation select; 00 ROR, 01 ASR, 10 LSR, 11 LSL.
REQ-006 The module SHALL have port amount, input, 4 bits: shift/rotate count, 0..15.
REQ-007 The module SHALL have port a, input, WIDTH bits: operand.
REQ-008 The module SHALL have port y, output, WIDTH bits: working/result register.
REQ-009 The module SHALL have port carry, output, 1 bit: last bit shifted or rotated out.
REQ-010 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 The module SHALL implement states IDLE, SHIFT and DONE, and all outputs SHALL be registered.
REQ-013 In IDLE with start=1 at an edge, the module SHALL latch a into y, op into an internal op register, and amount into a 4-bit counter cnt, and SHALL clear carry.
- Next state: DONE if amount==0, else SHIFT.
REQ-014 In IDLE with start=0, state, y and carry SHALL hold.
REQ-015 Each SHIFT cycle SHALL apply exactly one 1-bit step to y using the latched op, not the live op input.
- ROR: y[15]<=y[0], y[i]<=y[i+1]; carry<=y[0].
- ASR: y[15] kept, y[i]<=y[i+1]; carry<=y[0].
- LSR: y[15]<=0, y[i]<=y[i+1]; carry<=y[0].
- LSL: y[0]<=0, y[i+1]<=y[i]; carry<=y[15].
REQ-016 In SHIFT, each edge SHALL decrement cnt; when cnt==1 at the edge, the next state SHALL be DONE.
- SHIFT therefore lasts exactly amount cycles.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, y and carry SHALL hold the final result, and the next state SHALL be IDLE unconditionally.
REQ-018 Latency: with start sampled in cycle 0, done SHALL be high in cycle amount+1.
- amount=0: done in cycle 1, y=a, carry=0.
REQ-019 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored with no effect on the operation in progress.
- A new start is accepted no earlier than the cycle after done.
REQ-021 In IDLE, y and carry SHALL retain the last result until the next accepted start.
REQ-022 op, amount and a SHALL be don't-care except in the cycle start is accepted.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, y=0, carry=0, busy=0, done=0 and cnt=0, in any state including mid-SHIFT.
REQ-024 rst SHALL take priority over start in the same cycle.
REQ-025 The first start after rst deasserts SHALL behave exactly as from power-up reset.

Verification
REQ-026 ROR, a=0x0001, amount=1 -> done in cycle 2, y=0x8000, carry=1, busy high in cycles 1-2.
REQ-027 ASR, a=0x8004, amount=3 -> done in cycle 4, y=0xF000, carry=1.
REQ-028 LSL, a=0x8001, amount=15 -> done in cycle 16, y=0x8000, carry=0; LSR, a=0x1234, amount=0 -> done in cycle 1, y=0x1234, carry=0.
REQ-029 ROR, a=0x000F, amount=4; start re-asserted in cycle 2 with op=LSL, a=0xFFFF -> done in cycle 5 only, y=0xF000, carry=1, and no second operation starts.
REQ-030 LSR, a=0xFFFF, amount=8; rst in cycle 3 -> cycle 4 shows busy=0, done=0, y=0x0000, carry=0, and no done pulse follows.
- A subsequent ROR, a=0x0002, amount=1 -> y=0x0001, carry=0 after 2 cycles.
REQ-031 Back-to-back: start held high continuously with amount=2 -> operations accepted in cycles 0, 4, 8, ..., with done in cycles 3, 7, 11, ...

Source files
------------

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer
//  Purpose  : Multi-cycle serial shifter. A start in IDLE latches an operand,
//             an op (ROR/ASR/LSR/LSL) and a count; one 1-bit step is applied
//             per SHIFT cycle, then a one-cycle done pulse is issued.
//  Revision : 1.0  initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [3:0]       amount,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [1:0] c_OP_ROR = 2'b00;
    localparam logic [1:0] c_OP_ASR = 2'b01;
    localparam logic [1:0] c_OP_LSR = 2'b10;
    localparam logic [1:0] c_OP_LSL = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] w_y_nxt;
    logic             r_carry;
    logic             w_carry_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic [WIDTH-1:0] w_step_y;
    logic             w_step_carry;

    // State and datapath registers; reset clears everything, even mid-shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_y     <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= 4'd0;
            r_op    <= c_OP_ROR;
        end else begin
            r_state <= w_state_nxt;
            r_y     <= w_y_nxt;
            r_carry <= w_carry_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    // Next-state logic; a zero count skips SHIFT and goes straight to DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (amount == 4'd0) ? c_ST_DONE : c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Single 1-bit step of the latched operation
    always_comb begin
        w_step_y     = r_y;
        w_step_carry = r_y[0];
        case (r_op)
            c_OP_ROR: w_step_y = {r_y[0], r_y[WIDTH-1:1]};
            c_OP_ASR: w_step_y = {r_y[WIDTH-1], r_y[WIDTH-1:1]};
            c_OP_LSR: w_step_y = {1'b0, r_y[WIDTH-1:1]};
            c_OP_LSL: begin
                w_step_y     = {r_y[WIDTH-2:0], 1'b0};
                w_step_carry = r_y[WIDTH-1];
            end
            default: begin
                w_step_y     = r_y;
                w_step_carry = r_y[0];
            end
        endcase
    end

    // Output/datapath next values; busy and done are decoded from the next state
    always_comb begin
        w_y_nxt     = r_y;
        w_carry_nxt = r_carry;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_y_nxt     = a;
                    w_carry_nxt = 1'b0;
                    w_cnt_nxt   = amount;
                    w_op_nxt    = op;
                end
            end
            c_ST_SHIFT: begin
                w_y_nxt     = w_step_y;
                w_carry_nxt = w_step_carry;
                w_cnt_nxt   = r_cnt - 4'd1;
            end
            default: begin
                w_y_nxt     = r_y;
                w_carry_nxt = r_carry;
            end
        endcase
        w_busy_nxt = (w_state_nxt != c_ST_IDLE);
        w_done_nxt = (w_state_nxt == c_ST_DONE);
    end

    assign y     = r_y;
    assign carry = r_carry;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_sequencer
//  Purpose  : Scoreboard bench for shift_sequencer with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_sequencer;

    localparam logic [1:0] c_ROR = 2'b00;
    localparam logic [1:0] c_ASR = 2'b01;
    localparam logic [1:0] c_LSR = 2'b10;
    localparam logic [1:0] c_LSL = 2'b11;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic [15:0] a;
    logic [15:0] y;
    logic        carry;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] y;
        logic        c;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    shift_sequencer #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .amount (amount),
        .a      (a),
        .y      (y),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number; advances on every rising edge
    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: compares each done pulse against the oldest expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result_y", {16'd0, y}, {16'd0, e.y});
                chk("result_carry", {31'd0, carry}, {31'd0, e.c});
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("missing_done", cyc, e.cyc);
        end
    end

    // Issue one operation, expect its result, and return once back in IDLE
    task automatic run_op(input logic [1:0] o, input logic [3:0] amt,
                          input logic [15:0] av, input logic [15:0] ey,
                          input logic ec);
        start  = 1'b1;
        op     = o;
        amount = amt;
        a      = av;
        q.push_back('{ey, ec, cyc + int'(amt) + 1});
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = 16'hDEAD;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        repeat (int'(amt) + 1) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        amount = 4'd0;
        a      = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_y", {16'd0, y}, 32'd0);
        chk("reset_carry", {31'd0, carry}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(c_ROR, 4'd1,  16'h0001, 16'h8000, 1'b1);
        run_op(c_ASR, 4'd3,  16'h8004, 16'hF000, 1'b1);
        run_op(c_LSL, 4'd15, 16'h8001, 16'h8000, 1'b0);
        run_op(c_LSR, 4'd0,  16'h1234, 16'h1234, 1'b0);
        run_op(c_ASR, 4'd15, 16'h7FFF, 16'h0000, 1'b1);
        run_op(c_LSR, 4'd15, 16'h8000, 16'h0001, 1'b0);
        run_op(c_ROR, 4'd8,  16'hA5A5, 16'hA5A5, 1'b1);

        // Result is retained while idle
        repeat (2) @(negedge clk);
        chk("idle_hold_y", {16'd0, y}, 32'h0000_A5A5);
        chk("idle_hold_carry", {31'd0, carry}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Start re-asserted mid-operation is ignored
        start = 1'b1; op = c_ROR; amount = 4'd4; a = 16'h000F;
        q.push_back('{16'hF000, 1'b1, cyc + 5});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = c_LSL; amount = 4'd4; a = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("ignored_start_busy", {31'd0, busy}, 32'd0);
        chk("ignored_start_y", {16'd0, y}, 32'h0000_F000);

        // Reset mid-shift aborts the operation without a done pulse
        start = 1'b1; op = c_LSR; amount = 4'd8; a = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_y", {16'd0, y}, 32'd0);
        chk("abort_carry", {31'd0, carry}, 32'd0);
        repeat (10) @(negedge clk);
        run_op(c_ROR, 4'd1, 16'h0002, 16'h0001, 1'b0);

        // Reset wins over a simultaneous start
        rst = 1'b1; start = 1'b1; op = c_ROR; amount = 4'd1; a = 16'hFFFF;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        chk("rst_prio_y", {16'd0, y}, 32'd0);
        repeat (3) @(negedge clk);

        // Start held high: accepts every fourth cycle with amount=2
        start = 1'b1; op = c_LSL; amount = 4'd2; a = 16'h4001;
        q.push_back('{16'h0004, 1'b1, cyc + 3});
        q.push_back('{16'h0004, 1'b1, cyc + 7});
        q.push_back('{16'h0004, 1'b1, cyc + 11});
        repeat (9) @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);

        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
